axis_ctrlsrc_offset_cal: RTL and testbench

Offset-calibration sequencer for the control-source select stage. On request it freezes the feedback path, waits a settle interval, averages 2^LOG2_NAVG valid samples of the raw control-source stream, and latches the negated mean as `signal_offset`. That offset feeds the selector so the remaining DC is removed from the linear path. It also owns the `selection_ln` register, forcing the linear path while calibrating.

---
 rtl/axis_ctrlsrc_offset_cal.sv | 146 ++++++++++++++
 tb/tb_axis_ctrlsrc_offset_cal.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_ctrlsrc_offset_cal.sv
// Offset-calibration sequencer for the control-source select stage.
// Freezes the feedback path, waits a settle interval, averages 2^LOG2_NAVG valid
// samples and latches the negated mean as signal_offset.
// Optional accumulation watchdog: define CTRLSRC_CAL_TIMEOUT_EN to enable it.
module axis_ctrlsrc_offset_cal #(
  parameter int unsigned SAXIS_DATA_WIDTH = 32,
  parameter int unsigned LOG2_NAVG        = 10,
  parameter int unsigned SETTLE_CYCLES    = 256,
  parameter int unsigned TIMEOUT_CYCLES   = 65536
) (
  input  logic                        a_clk,
  input  logic                        a_rst,
  input  logic [SAXIS_DATA_WIDTH-1:0] S_AXIS_tdata,
  input  logic                        S_AXIS_tvalid,
  input  logic                        cal_start,
  input  logic                        cal_abort,
  input  logic [1:0]                  selection_ln_req,
  output logic [1:0]                  selection_ln,
  output logic [SAXIS_DATA_WIDTH-1:0] signal_offset,
  output logic                        ctrl_hold,
  output logic                        cal_done,
  output logic                        cal_error
);

  localparam int unsigned W    = SAXIS_DATA_WIDTH;
  localparam int unsigned AccW = SAXIS_DATA_WIDTH + LOG2_NAVG;
  localparam int unsigned CntW = LOG2_NAVG + 1;
  localparam int unsigned SetW = $clog2(SETTLE_CYCLES + 1);

  localparam logic [CntW-1:0] LastSmp    = CntW'((2 ** LOG2_NAVG) - 1);
  localparam logic [SetW-1:0] SettleLast = SetW'(SETTLE_CYCLES - 1);
  localparam logic [W-1:0]    MinVal     = {1'b1, {(W-1){1'b0}}};
  localparam logic [W-1:0]    MaxVal     = {1'b0, {(W-1){1'b1}}};

  typedef enum logic [1:0] {StIdle, StSettle, StAccum, StLatch} state_e;

  state_e          state_q, state_d;
  logic [SetW-1:0] settle_cnt_q;
  logic [CntW-1:0] smp_cnt_q;
  logic [AccW-1:0] acc_q;
  logic [AccW-1:0] sample_ext;
  logic [W-1:0]    mean;
  logic [W-1:0]    offset_next;
  logic            hold_d;
  logic            timeout_hit;

`ifdef CTRLSRC_CAL_TIMEOUT_EN
  localparam int unsigned WdW    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WdW-1:0] WdLast = WdW'(TIMEOUT_CYCLES - 1);

  logic [WdW-1:0] wd_cnt_q;
  logic           cal_error_q;

  // Watchdog fires on an idle cycle that completes TIMEOUT_CYCLES without a sample
  assign timeout_hit = (state_q == StAccum) && !cal_abort && !S_AXIS_tvalid &&
                       (wd_cnt_q == WdLast);
  assign cal_error   = cal_error_q;
`else
  assign timeout_hit = 1'b0;
  assign cal_error   = 1'b0;
`endif

  assign sample_ext = {{LOG2_NAVG{S_AXIS_tdata[W-1]}}, S_AXIS_tdata};
  // Arithmetic shift right by LOG2_NAVG, truncated to sample width (always fits)
  assign mean        = acc_q[LOG2_NAVG +: W];
  assign offset_next = (mean == MinVal) ? MaxVal : (W'(0) - mean);

  // Hold also covers the cal_done cycle so downstream resumes with the new offset
  assign hold_d = (state_d != StIdle) || (state_q == StLatch);

  // Next-state decode; abort has priority over every other transition
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (cal_start && !cal_abort) state_d = StSettle;
      end
      StSettle: begin
        if (cal_abort)                         state_d = StIdle;
        else if (settle_cnt_q == SettleLast)   state_d = StAccum;
      end
      StAccum: begin
        if (cal_abort)                                state_d = StIdle;
        else if (S_AXIS_tvalid && smp_cnt_q == LastSmp) state_d = StLatch;
        else if (timeout_hit)                         state_d = StIdle;
      end
      StLatch: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State, datapath and registered outputs
  always_ff @(posedge a_clk or posedge a_rst) begin
    if (a_rst) begin
      state_q       <= StIdle;
      settle_cnt_q  <= '0;
      smp_cnt_q     <= '0;
      acc_q         <= '0;
      signal_offset <= '0;
      selection_ln  <= 2'b00;
      ctrl_hold     <= 1'b0;
      cal_done      <= 1'b0;
`ifdef CTRLSRC_CAL_TIMEOUT_EN
      wd_cnt_q      <= '0;
      cal_error_q   <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      cal_done     <= 1'b0;
      ctrl_hold    <= hold_d;
      selection_ln <= hold_d ? 2'b00 : selection_ln_req;
      unique case (state_q)
        StIdle: begin
          if (state_d == StSettle) begin
            settle_cnt_q <= '0;
            smp_cnt_q    <= '0;
            acc_q        <= '0;
`ifdef CTRLSRC_CAL_TIMEOUT_EN
            wd_cnt_q     <= '0;
            cal_error_q  <= 1'b0;
`endif
          end
        end
        StSettle: begin
          settle_cnt_q <= settle_cnt_q + 1'b1;
        end
        StAccum: begin
          if (S_AXIS_tvalid) begin
            acc_q     <= acc_q + sample_ext;
            smp_cnt_q <= smp_cnt_q + 1'b1;
          end
`ifdef CTRLSRC_CAL_TIMEOUT_EN
          wd_cnt_q <= S_AXIS_tvalid ? '0 : wd_cnt_q + 1'b1;
          if (timeout_hit) cal_error_q <= 1'b1;
`endif
        end
        StLatch: begin
          signal_offset <= offset_next;
          cal_done      <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_axis_ctrlsrc_offset_cal.sv
// Self-checking bench for axis_ctrlsrc_offset_cal with a small behavioural model.
module tb_axis_ctrlsrc_offset_cal;

  localparam int W = 32;
  localparam int L = 4;
  localparam int S = 8;
  localparam int T = 32;
  localparam int N = 16;

  logic          a_clk = 1'b0;
  logic          a_rst;
  logic [W-1:0]  S_AXIS_tdata;
  logic          S_AXIS_tvalid;
  logic          cal_start;
  logic          cal_abort;
  logic [1:0]    selection_ln_req;
  logic [1:0]    selection_ln;
  logic [W-1:0]  signal_offset;
  logic          ctrl_hold;
  logic          cal_done;
  logic          cal_error;

  int checks   = 0;
  int failures = 0;

  logic [31:0] stim_data  [0:159];
  logic        stim_valid [0:159];
  logic [31:0] model_off;

  axis_ctrlsrc_offset_cal #(
    .SAXIS_DATA_WIDTH(W),
    .LOG2_NAVG       (L),
    .SETTLE_CYCLES   (S),
    .TIMEOUT_CYCLES  (T)
  ) dut (
    .a_clk           (a_clk),
    .a_rst           (a_rst),
    .S_AXIS_tdata    (S_AXIS_tdata),
    .S_AXIS_tvalid   (S_AXIS_tvalid),
    .cal_start       (cal_start),
    .cal_abort       (cal_abort),
    .selection_ln_req(selection_ln_req),
    .selection_ln    (selection_ln),
    .signal_offset   (signal_offset),
    .ctrl_hold       (ctrl_hold),
    .cal_done        (cal_done),
    .cal_error       (cal_error)
  );

  always #5 a_clk = ~a_clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Offset = -floor(sum / N), saturating when the mean is the most negative value
  function automatic logic [31:0] ref_offset(input longint sum);
    longint mean;
    longint min_v;
    min_v = -(longint'(1) << 31);
    mean  = sum / N;
    if (sum < 0 && (sum % N) != 0) mean = mean - 1;
    if (mean == min_v) return 32'h7FFF_FFFF;
    return 32'(-mean);
  endfunction

  // mode 0: constant a, always valid; 1: alternating a/b on odd cycles;
  // 2: random data, ~70% valid; 3: valid only on cycles 9..11
  task automatic fill(input int mode, input logic [31:0] a, input logic [31:0] b);
    logic tog;
    tog = 1'b0;
    for (int j = 0; j < 160; j++) begin
      unique case (mode)
        0: begin stim_valid[j] = 1'b1; stim_data[j] = a; end
        1: begin
          stim_valid[j] = (j % 2) == 1;
          if (stim_valid[j]) begin
            stim_data[j] = tog ? b : a;
            tog = ~tog;
          end else begin
            stim_data[j] = 32'h7FFF_FFFF;
          end
        end
        2: begin
          stim_valid[j] = ($urandom_range(0, 9) < 7) || (j >= 60);
          stim_data[j]  = $urandom;
        end
        default: begin stim_valid[j] = (j >= 9 && j <= 11); stim_data[j] = a; end
      endcase
    end
  endtask

  task automatic drive(input int j);
    S_AXIS_tvalid = stim_valid[j];
    S_AXIS_tdata  = stim_data[j];
  endtask

  // Full calibration from a start pulse against the stimulus arrays
  task automatic run_cal(input string tag);
    int acc_n, m_idx, hold_cnt, done_cnt, done_idx;
    longint sum;
    logic [31:0] exp_off;
    acc_n = 0; m_idx = -1; hold_cnt = 0; done_cnt = 0; done_idx = -1;
    sum = 0; exp_off = model_off;
    cal_start = 1'b1;
    S_AXIS_tvalid = 1'b0;
    @(posedge a_clk); #1;
    cal_start = 1'b0;
    check_eq({tag, "_hold_start"}, ctrl_hold, 1);
    check_eq({tag, "_sel_start"}, selection_ln, 0);
    hold_cnt = ctrl_hold ? 1 : 0;
    drive(1);
    for (int j = 1; j < 150; j++) begin
      if (j >= S + 1 && acc_n < N && stim_valid[j]) begin
        sum += longint'($signed(stim_data[j]));
        acc_n++;
        if (acc_n == N) begin
          m_idx   = j;
          exp_off = ref_offset(sum);
        end
      end
      @(posedge a_clk); #1;
      hold_cnt += ctrl_hold ? 1 : 0;
      if (cal_done) begin
        done_cnt++;
        done_idx = j;
      end
      if (m_idx >= 0 && j == m_idx) check_eq({tag, "_off_kept"}, signal_offset, model_off);
      if (m_idx >= 0 && j == m_idx + 1) check_eq({tag, "_offset"}, signal_offset, exp_off);
      if (m_idx >= 0 && j == m_idx + 2) break;
      drive(j + 1);
    end
    S_AXIS_tvalid = 1'b0;
    check_eq({tag, "_done_cnt"}, done_cnt, 1);
    check_eq({tag, "_done_at"}, done_idx, m_idx + 1);
    check_eq({tag, "_hold_cycles"}, hold_cnt, m_idx + 2);
    check_eq({tag, "_hold_end"}, ctrl_hold, 0);
    check_eq({tag, "_sel_end"}, selection_ln, selection_ln_req);
    model_off = exp_off;
  endtask

  initial begin
    int done_seen;
    a_rst = 1'b1;
    S_AXIS_tdata = '0; S_AXIS_tvalid = 1'b0;
    cal_start = 1'b0; cal_abort = 1'b0;
    selection_ln_req = 2'b01;
    model_off = 32'h0;
    repeat (2) @(posedge a_clk);
    #1;
    check_eq("rst_offset", signal_offset, 0);
    check_eq("rst_sel", selection_ln, 0);
    check_eq("rst_hold", ctrl_hold, 0);
    check_eq("rst_done", cal_done, 0);
    check_eq("rst_err", cal_error, 0);
    a_rst = 1'b0;
    @(posedge a_clk); #1;
    check_eq("sel_pass", selection_ln, 2'b01);
    selection_ln_req = 2'b10;
    #1 check_eq("sel_latency", selection_ln, 2'b01);
    @(posedge a_clk); #1;
    check_eq("sel_pass2", selection_ln, 2'b10);
    selection_ln_req = 2'b01;
    @(posedge a_clk); #1;

    fill(0, 32'h0000_1000, 32'h0); run_cal("const");
    fill(1, 32'd3, 32'd4);         run_cal("alt");
    fill(0, 32'h8000_0000, 32'h0); run_cal("sat");
    fill(0, 32'hFFFF_FD00, 32'h0); run_cal("neg");
    for (int r = 0; r < 4; r++) begin
      fill(2, 32'h0, 32'h0);
      run_cal($sformatf("rnd%0d", r));
    end

    // Abort after 5 accepted samples keeps the previous offset
    fill(0, 32'hFFFF_FFF0, 32'h0); run_cal("pre");
    fill(0, 32'h1234_5678, 32'h0);
    done_seen = 0;
    cal_start = 1'b1;
    @(posedge a_clk); #1;
    cal_start = 1'b0;
    for (int j = 1; j <= 13; j++) begin
      drive(j);
      @(posedge a_clk); #1;
      done_seen += cal_done ? 1 : 0;
    end
    cal_abort = 1'b1;
    drive(14);
    @(posedge a_clk); #1;
    cal_abort = 1'b0;
    S_AXIS_tvalid = 1'b0;
    done_seen += cal_done ? 1 : 0;
    check_eq("abort_hold", ctrl_hold, 0);
    check_eq("abort_off", signal_offset, model_off);
    @(posedge a_clk); #1;
    done_seen += cal_done ? 1 : 0;
    check_eq("abort_sel", selection_ln, 2'b01);
    check_eq("abort_off2", signal_offset, 32'h10);
    check_eq("abort_nodone", done_seen, 0);

    // Simultaneous start and abort in idle does nothing
    cal_start = 1'b1; cal_abort = 1'b1;
    @(posedge a_clk); #1;
    cal_start = 1'b0; cal_abort = 1'b0;
    check_eq("sa_hold", ctrl_hold, 0);
    @(posedge a_clk); #1;
    check_eq("sa_hold2", ctrl_hold, 0);
    check_eq("sa_sel", selection_ln, 2'b01);
    check_eq("sa_off", signal_offset, 32'h10);

    // Sample stream stalls after 3 samples
    fill(3, 32'h0000_0100, 32'h0);
    done_seen = 0;
    cal_start = 1'b1;
    @(posedge a_clk); #1;
    cal_start = 1'b0;
    for (int j = 1; j <= 11 + T + 4; j++) begin
      drive(j);
      @(posedge a_clk); #1;
      done_seen += cal_done ? 1 : 0;
`ifdef CTRLSRC_CAL_TIMEOUT_EN
      if (j == 11 + T - 1) check_eq("to_hold_before", ctrl_hold, 1);
      if (j == 11 + T) begin
        check_eq("to_hold", ctrl_hold, 0);
        check_eq("to_err", cal_error, 1);
        check_eq("to_off", signal_offset, model_off);
      end
`endif
    end
    S_AXIS_tvalid = 1'b0;
    check_eq("to_nodone", done_seen, 0);
`ifdef CTRLSRC_CAL_TIMEOUT_EN
    check_eq("to_err_sticky", cal_error, 1);
    cal_start = 1'b1;
    @(posedge a_clk); #1;
    cal_start = 1'b0;
    check_eq("to_err_clear", cal_error, 0);
    check_eq("to_restart_hold", ctrl_hold, 1);
`else
    check_eq("nto_hold", ctrl_hold, 1);
    check_eq("nto_err", cal_error, 0);
`endif
    cal_abort = 1'b1;
    @(posedge a_clk); #1;
    cal_abort = 1'b0;
    check_eq("to_abort_hold", ctrl_hold, 0);

    // Asynchronous reset in the middle of accumulation
    fill(0, 32'h0000_1000, 32'h0);
    cal_start = 1'b1;
    @(posedge a_clk); #1;
    cal_start = 1'b0;
    for (int j = 1; j <= 12; j++) begin
      drive(j);
      @(posedge a_clk); #1;
    end
    #2 a_rst = 1'b1;
    #1;
    check_eq("arst_off", signal_offset, 0);
    check_eq("arst_hold", ctrl_hold, 0);
    check_eq("arst_sel", selection_ln, 0);
    check_eq("arst_done", cal_done, 0);
    check_eq("arst_err", cal_error, 0);
    model_off = 32'h0;
    @(posedge a_clk); #1;
    a_rst = 1'b0;
    S_AXIS_tvalid = 1'b0;
    @(posedge a_clk); #1;
    fill(0, 32'h0000_0400, 32'h0); run_cal("post_rst");
    check_eq("post_rst_val", signal_offset, 32'hFFFF_FC00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
